fixed_divider: RTL and testbench

FIXED_DIVIDER -- requirements
Module: fixed_divider

---
 rtl/fixed_divider.sv | 180 ++++++++++++++++++
 tb/tb_fixed_divider.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_divider.sv
// rtl/fixed_divider.sv - signed fixed-point restoring divider, one quotient bit per cycle
//
// Computes out = i_A / i_B for signed QN-Q-1.Q operands. The magnitudes are divided
// as (|A| << Q) / |B| with a restoring divider that produces N+Q quotient bits, one
// per clock. The sign is then applied and overflow is detected.
//
// Build option: FIXED_DIVIDER_SATURATE_EN
//   defined   - overflowed results clamp to the most positive or most negative value
//   undefined - overflowed results wrap to the low N bits of the signed quotient
//
// Parameters:
//   N          word width of operands and result
//   Q          number of fractional bits
// Ports:
//   i_clk      clock; all state changes on the rising edge
//   i_rst      synchronous active-high reset
//   i_start    request, sampled only in IDLE
//   i_A        dividend, signed fixed-point
//   i_B        divisor, signed fixed-point
//   o_busy     high from acceptance through the o_done cycle
//   o_done     one-cycle pulse when out is valid
//   out        quotient, signed fixed-point, held until the next o_done
//   o_ovf      quotient overflowed the N-bit range, held
//   o_div_zero divisor was zero, held

module fixed_divider #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_A,
    input  logic [N-1:0] i_B,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] out,
    output logic         o_ovf,
    output logic         o_div_zero
);

    localparam int W  = N + Q;
    localparam int CW = $clog2(W + 1);

    localparam logic [N-1:0] MOST_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
    // Largest quotient magnitudes representable for each result sign.
    localparam logic [W-1:0] POS_LIMIT = {{(Q+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [W-1:0] NEG_LIMIT = POS_LIMIT + W'(1);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   dvd_q;      // dividend bits shift out the top, quotient bits shift in
    logic [N-1:0]   rem_q;      // partial remainder, always below the divisor
    logic [N-1:0]   div_q;      // divisor magnitude
    logic           neg_q;      // result sign
    logic           a_neg_q;    // dividend sign, selects the divide-by-zero result
    logic           dz_q;       // divisor was zero
    logic           busy_q;
    logic           done_q;
    logic [N-1:0]   out_q;
    logic           ovf_q;
    logic           div_zero_q;

    // Operand magnitudes; the most negative value maps onto itself as unsigned 2^(N-1).
    logic [N-1:0] abs_a;
    logic [N-1:0] abs_b;

    always_comb begin
        abs_a = i_A[N-1] ? (~i_A + N'(1)) : i_A;
        abs_b = i_B[N-1] ? (~i_B + N'(1)) : i_B;
    end

    // One restoring-division step. The shifted remainder needs N+1 bits because the
    // divisor magnitude can be as large as 2^(N-1).
    logic [N:0]   rem_sh;
    logic [N:0]   rem_diff;
    logic         q_bit;
    logic [N-1:0] rem_next;

    always_comb begin
        rem_sh   = {rem_q, dvd_q[W-1]};
        rem_diff = rem_sh - {1'b0, div_q};
        q_bit    = (rem_sh >= {1'b0, div_q});
        rem_next = q_bit ? rem_diff[N-1:0] : rem_sh[N-1:0];
    end

    // Result formatting from the finished quotient magnitude held in dvd_q.
    logic [W-1:0] signed_res;
    logic         res_ovf;
    logic [N-1:0] res_out;
    logic [N-1:0] dz_out;

    always_comb begin
        // Negating zero yields zero, so a zero quotient is never given a sign.
        signed_res = neg_q ? (~dvd_q + W'(1)) : dvd_q;
        res_ovf    = neg_q ? (dvd_q > NEG_LIMIT) : (dvd_q > POS_LIMIT);
`ifdef FIXED_DIVIDER_SATURATE_EN
        res_out    = res_ovf ? (neg_q ? MOST_NEG : MOST_POS) : signed_res[N-1:0];
`else
        res_out    = signed_res[N-1:0];
`endif
        dz_out     = a_neg_q ? MOST_NEG : MOST_POS;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            neg_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_q      <= '0;
            ovf_q      <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (i_start) begin
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        dvd_q   <= {abs_a, {Q{1'b0}}};
                        rem_q   <= '0;
                        div_q   <= abs_b;
                        neg_q   <= i_A[N-1] ^ i_B[N-1];
                        a_neg_q <= i_A[N-1];
                        dz_q    <= (i_B == '0);
                        state_q <= (i_B == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    dvd_q <= {dvd_q[W-2:0], q_bit};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (dz_q) begin
                        out_q      <= dz_out;
                        ovf_q      <= 1'b1;
                        div_zero_q <= 1'b1;
                    end else begin
                        out_q      <= res_out;
                        ovf_q      <= res_ovf;
                        div_zero_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign out        = out_q;
    assign o_ovf      = ovf_q;
    assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_fixed_divider.sv
// tb/tb_fixed_divider.sv - self-checking bench for fixed_divider

module tb_fixed_divider;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_A = '0;
    logic [15:0] i_B = '0;
    logic        o_busy;
    logic        o_done;
    logic [15:0] out;
    logic        o_ovf;
    logic        o_div_zero;

    fixed_divider #(.N(16), .Q(8)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_A        (i_A),
        .i_B        (i_B),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .out        (out),
        .o_ovf      (o_ovf),
        .o_div_zero (o_div_zero)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eout;
        logic        eovf;
        logic        edz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] eout;
        logic        eovf;
        logic        edz;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain integer division of the scaled magnitudes.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] o, output logic ovf, output logic dz);
        longint la, lb, mag, res;
        logic   neg;
        if (b == 16'h0) begin
            dz  = 1'b1;
            ovf = 1'b1;
            o   = a[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            dz  = 1'b0;
            la  = longint'($signed(a));
            lb  = longint'($signed(b));
            if (la < 0) la = -la;
            if (lb < 0) lb = -lb;
            mag = (la * 256) / lb;
            neg = a[15] ^ b[15];
            ovf = neg ? (mag > 32768) : (mag > 32767);
            res = neg ? -mag : mag;
            o   = res[15:0];
`ifdef FIXED_DIVIDER_SATURATE_EN
            if (ovf) o = neg ? 16'h8000 : 16'h7FFF;
`endif
        end
    endtask

    task automatic add_vec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eo,
                           input logic eovf, input logic edz, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.eout = eo; v.eovf = eovf; v.edz = edz; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Wait for o_done, starting from n edges already elapsed since acceptance.
    task automatic wait_done(input string name, input int n_start, input int lat);
        int   n;
        exp_t e;
        n = n_start;
        while (n < 80) begin
            @(posedge i_clk); #1;
            n++;
            if (o_done) break;
        end
        chk({name, "_done_seen"}, 32'(o_done), 32'd1);
        chk({name, "_latency"}, 32'(n), 32'(lat));
        if (o_done && sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, "_out"}, 32'(out), 32'(e.eout));
            chk({name, "_ovf"}, 32'(o_ovf), 32'(e.eovf));
            chk({name, "_dz"}, 32'(o_div_zero), 32'(e.edz));
            chk({name, "_busy_in_done"}, 32'(o_busy), 32'd1);
        end
        @(posedge i_clk); #1;
        chk({name, "_done_pulse"}, 32'(o_done), 32'd0);
        chk({name, "_busy_after"}, 32'(o_busy), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eo, input logic eovf, input logic edz, input int lat);
        exp_t e;
        i_A = a; i_B = b; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_A = 16'($urandom);
        i_B = 16'($urandom);
        e.eout = eo; e.eovf = eovf; e.edz = edz;
        sb.push_back(e);
        chk({name, "_busy_accept"}, 32'(o_busy), 32'd1);
        chk({name, "_no_early_done"}, 32'(o_done), 32'd0);
        wait_done(name, 0, lat);
    endtask

    function automatic int count_dones_init();
        return 0;
    endfunction

    initial begin
        logic [15:0] ra, rb, ro;
        logic        rovf, rdz;
        int          ndone;
        exp_t        e;

        // Reset state.
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        chk("rst_dz", 32'(o_div_zero), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Fixed vectors.
        add_vec(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25);
        add_vec(16'hFE80, 16'h0080, 16'hFD00, 1'b0, 1'b0, 25);
        add_vec(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25);
        add_vec(16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 25);
`ifdef FIXED_DIVIDER_SATURATE_EN
        add_vec(16'h6400, 16'h0040, 16'h7FFF, 1'b1, 1'b0, 25);
        add_vec(16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 25);
`else
        add_vec(16'h6400, 16'h0040, 16'h9000, 1'b1, 1'b0, 25);
        add_vec(16'h8000, 16'hFF00, 16'h8000, 1'b1, 1'b0, 25);
`endif
        add_vec(16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 25);
        add_vec(16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0, 25);
        add_vec(16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1);
        add_vec(16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1, 1);
        add_vec(16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1);
        // Random vectors with reference-model expectations.
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(1, 65535));
            if (i < 4) rb = {{4{rb[15]}}, rb[11:0]};
            if (rb == 16'h0) rb = 16'h0001;
            model(ra, rb, ro, rovf, rdz);
            add_vec(ra, rb, ro, rovf, rdz, 25);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].eout,
                   vecs[i].eovf, vecs[i].edz, vecs[i].lat);
        end

        // Second start during CALC is ignored.
        i_A = 16'h0300; i_B = 16'h0200; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        e.eout = 16'h0180; e.eovf = 1'b0; e.edz = 1'b0;
        sb.push_back(e);
        repeat (5) @(posedge i_clk);
        #1;
        i_A = 16'h7000; i_B = 16'h0100; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done("restart", 6, 25);
        ndone = count_dones_init();
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk); #1;
            if (o_done) ndone++;
        end
        chk("restart_extra_done", 32'(ndone), 32'd0);

        // Reset during CALC aborts; start coincident with reset is ignored.
        i_A = 16'h0100; i_B = 16'h0300; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        i_rst = 1'b1; i_start = 1'b1; i_A = 16'h0300; i_B = 16'h0200;
        @(posedge i_clk); #1;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_out", 32'(out), 32'd0);
        chk("abort_ovf", 32'(o_ovf), 32'd0);
        chk("abort_dz", 32'(o_div_zero), 32'd0);
        i_rst = 1'b0; i_start = 1'b0;
        ndone = count_dones_init();
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) ndone++;
        end
        chk("abort_quiet", 32'(ndone), 32'd0);
        run_op("after_abort", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
